pipe_hazard_ctrl: RTL and testbench

//   Consumer of the IF/ID, ID/EX, EX/MEM and MEM/WB pipe register outputs.

---
 rtl/pipe_hazard_ctrl.sv | 120 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hold/flush/bubble controller with halt drain and event counters
module pipe_hazard_ctrl #(
  parameter int REG_W     = 4,
  parameter int CNT_W     = 16,
  parameter int DRAIN_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,        // active-high synchronous reset
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_vld,
  input  logic             id_rt_vld,
  input  logic             id_hlt,
  input  logic             ex_dm_rd_en,
  input  logic [REG_W-1:0] ex_wr_reg,
  input  logic             mem_redirect,
  input  logic             wb_hlt,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_flush,
  output logic             halted,
  output logic             drain_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int DC_W = $clog2(DRAIN_MAX) + 1;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  state_t          state, state_nxt;
  logic [DC_W-1:0] drain_cnt, drain_cnt_nxt;
  logic            stall_evt, flush_evt, drain_err_set;
  logic            lu;

  // Load-use hazard: load in EX writes a register the ID instruction reads; R0 is exempt.
  assign lu = ex_dm_rd_en && (ex_wr_reg != '0) &&
              ((id_rs_vld && (id_rs == ex_wr_reg)) || (id_rt_vld && (id_rt == ex_wr_reg)));

  assign halted = (state == S_HALTED);

  // Next-state and control decode; everything is suppressed while reset is asserted.
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    pc_hold       = 1'b0;
    if_id_hold    = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_flush  = 1'b0;
    stall_evt     = 1'b0;
    flush_evt     = 1'b0;
    drain_err_set = 1'b0;
    if (!rst_n) begin
      case (state)
        S_RUN: begin
          if (mem_redirect) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_flush = 1'b1;
            flush_evt    = 1'b1;
          end else if (lu) begin
            pc_hold      = 1'b1;
            if_id_hold   = 1'b1;
            id_ex_bubble = 1'b1;
            stall_evt    = 1'b1;
          end else if (id_hlt) begin
            state_nxt     = S_DRAIN;
            drain_cnt_nxt = '0;
          end
        end
        S_DRAIN: begin
          pc_hold       = 1'b1;
          if_id_flush   = 1'b1;
          drain_cnt_nxt = drain_cnt + 1'b1;
          if (mem_redirect) begin
            // An older branch squashes the HLT: resume fetching from alt_pc.
            pc_hold      = 1'b0;
            id_ex_bubble = 1'b1;
            ex_mem_flush = 1'b1;
            flush_evt    = 1'b1;
            state_nxt    = S_RUN;
          end else if (wb_hlt) begin
            state_nxt = S_HALTED;
          end else if (drain_cnt == DC_W'(DRAIN_MAX - 1)) begin
            state_nxt     = S_HALTED;
            drain_err_set = 1'b1;
          end
        end
        S_HALTED: begin
          pc_hold      = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          ex_mem_flush = 1'b1;
        end
        default: state_nxt = S_RUN;
      endcase
    end
  end

  // State, drain timer, sticky error and saturating event counters.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= S_RUN;
      drain_cnt <= '0;
      drain_err <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      if (drain_err_set) drain_err <= 1'b1;
      if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] id_rs = '0, id_rt = '0, ex_wr_reg = '0;
  logic       id_rs_vld = 1'b0, id_rt_vld = 1'b0, id_hlt = 1'b0;
  logic       ex_dm_rd_en = 1'b0, mem_redirect = 1'b0, wb_hlt = 1'b0;
  logic       pc_hold, if_id_hold, if_id_flush, id_ex_bubble, ex_mem_flush;
  logic       halted, drain_err;
  logic [3:0] stall_cnt, flush_cnt;

  typedef struct {
    string      nm;
    logic [4:0] ctrl;   // {pc_hold, if_id_hold, if_id_flush, id_ex_bubble, ex_mem_flush}
    logic       hl;
    logic       de;
    logic [3:0] sc;
    logic [3:0] fc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  pipe_hazard_ctrl #(.REG_W(4), .CNT_W(4), .DRAIN_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_vld(id_rs_vld), .id_rt_vld(id_rt_vld),
    .id_hlt(id_hlt), .ex_dm_rd_en(ex_dm_rd_en), .ex_wr_reg(ex_wr_reg),
    .mem_redirect(mem_redirect), .wb_hlt(wb_hlt),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ex_mem_flush(ex_mem_flush),
    .halted(halted), .drain_err(drain_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the edge and queue the expected response.
  task automatic step(input string nm, input logic r, input logic ld, input logic [3:0] wr,
                      input logic [3:0] rs, input logic rsv, input logic [3:0] rt, input logic rtv,
                      input logic hlt, input logic redir, input logic wbh,
                      input logic [4:0] ctrl, input logic hl, input logic de,
                      input logic [3:0] sc, input logic [3:0] fc);
    exp_t e;
    @(posedge clk);
    #2;
    rst_n = r; ex_dm_rd_en = ld; ex_wr_reg = wr;
    id_rs = rs; id_rs_vld = rsv; id_rt = rt; id_rt_vld = rtv;
    id_hlt = hlt; mem_redirect = redir; wb_hlt = wbh;
    e.nm = nm; e.ctrl = ctrl; e.hl = hl; e.de = de; e.sc = sc; e.fc = fc;
    sb.push_back(e);
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest queued expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t       e;
      logic [4:0] got;
      e   = sb.pop_front();
      got = {pc_hold, if_id_hold, if_id_flush, id_ex_bubble, ex_mem_flush};
      checks++;
      if (got !== e.ctrl || halted !== e.hl || drain_err !== e.de ||
          stall_cnt !== e.sc || flush_cnt !== e.fc) begin
        errors++;
        $display("FAIL %s: got ctrl=%b halted=%b drain_err=%b stall=%0d flush=%0d, expected ctrl=%b halted=%b drain_err=%b stall=%0d flush=%0d",
                 e.nm, got, halted, drain_err, stall_cnt, flush_cnt,
                 e.ctrl, e.hl, e.de, e.sc, e.fc);
      end
    end
  end

  initial begin
    int wait_cyc;
    repeat (2) @(posedge clk);
    //    name        r ld wr rs rsv rt rtv h rd wb ctrl     hl de sc fc
    step("rst_force", 1, 1, 3, 3, 1, 0, 0, 0, 1, 0, 5'b00000, 0, 0, 0, 0);
    // 1: load-use on rs
    step("lu_rs",     0, 1, 3, 3, 1, 0, 0, 0, 0, 0, 5'b11010, 0, 0, 0, 0);
    step("lu_clear",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 1, 0);
    // 2: R0 and unread sources never stall; rt path does
    step("lu_r0",     0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 5'b00000, 0, 0, 1, 0);
    step("lu_novld",  0, 1, 5, 5, 0, 5, 0, 0, 0, 0, 5'b00000, 0, 0, 1, 0);
    step("lu_rt",     0, 1, 7, 2, 1, 7, 1, 0, 0, 0, 5'b11010, 0, 0, 1, 0);
    step("idle1",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 2, 0);
    // 3: redirect beats load-use
    step("redir_lu",  0, 1, 3, 3, 1, 0, 0, 0, 1, 0, 5'b00111, 0, 0, 2, 0);
    step("idle2",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 2, 1);
    // 4: halt drain ended by wb_hlt
    step("hlt",       0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 0, 0, 2, 1);
    step("drain0",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10100, 0, 0, 2, 1);
    step("drain1",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10100, 0, 0, 2, 1);
    step("drain2_wb", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b10100, 0, 0, 2, 1);
    step("halted0",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10111, 1, 0, 2, 1);
    step("halted_ign",0, 1, 3, 3, 1, 0, 0, 1, 1, 0, 5'b10111, 1, 0, 2, 1);
    step("halt_rst",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 0, 2, 1);
    step("post_rst",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0);
    // 5: redirect squashes HLT in DRAIN; then drain timeout
    step("hlt2",      0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 0, 0, 0, 0);
    step("d2_0",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10100, 0, 0, 0, 0);
    step("d2_redir",  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00111, 0, 0, 0, 0);
    step("back_run",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 1);
    step("hlt3",      0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++)
      step("d3",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10100, 0, 0, 0, 1);
    step("tmo_halt",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10111, 1, 1, 0, 1);
    step("tmo_rst",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 1, 0, 1);
    step("tmo_clr",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0);
    // 6: stall counter saturation, then reset in the middle of DRAIN
    for (int i = 0; i < 17; i++)
      step("sat",     0, 1, 3, 3, 1, 0, 0, 0, 0, 0, 5'b11010, 0, 0, (i > 15) ? 4'd15 : 4'(i), 0);
    step("sat_hold",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 15, 0);
    step("hlt4",      0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 0, 0, 15, 0);
    step("d4_0",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10100, 0, 0, 15, 0);
    step("d4_rst",    1, 1, 3, 3, 1, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 15, 0);
    step("rst_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0);
    step("rst_run",   0, 1, 3, 3, 1, 0, 0, 0, 0, 0, 5'b11010, 0, 0, 0, 0);
    step("final",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 1, 0);
    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_queue: %0d expectations left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
